axis_frame_gen: RTL and testbench
=================================

Name: axis_frame_gen

Overview:
- AXI4-Stream frame source for the C2H DMA path: generates a commanded number of frames of programmable byte length with a deterministic byte pattern.
- Drives the slave side of the C2H stream FIFO. It is the transmitter feeding that buffer and is used for DMA bring-up, throughput and integrity testing.
- Honours downstream backpressure. Can optionally mark frames bad via tuser to exercise drop-bad-frame logic downstream.

Parameters:
- DATA_WIDTH, 64, stream data width in bits (multiple of 8).
- KEEP_WIDTH, DATA_WIDTH/8, bytes per beat.
- USER_WIDTH, 1, tuser width; bit 0 carries the bad-frame flag.
- LEN_WIDTH, 16, width of the frame length in bytes.
- CNT_WIDTH, 16, width of the frame count and sent counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  LEN_WIDTH  frame length in bytes
- cmd_count  in  CNT_WIDTH  number of frames
- cmd_seed  in  8  pattern seed
- cmd_bad  in  1  mark every frame bad on its last beat
- abort  in  1  stop after the current frame
- m_axis_tdata  out  DATA_WIDTH  data
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tvalid  out  1  valid
- m_axis_tready  in  1  ready
- m_axis_tlast  out  1  end of frame
- m_axis_tuser  out  USER_WIDTH  bit 0 = bad flag, other bits 0
- busy  out  1  high in SEND or DONE
- done  out  1  one-cycle pulse at command completion
- frames_sent  out  CNT_WIDTH  frames completed for the current/last command

Behaviour:
- Reset (async, any state): state=IDLE, cmd_ready=1, m_axis_tvalid=0, tdata/tkeep/tlast/tuser=0, busy=0, done=0, frames_sent=0. A frame in flight is truncated with no tlast; downstream must be reset as well.
- All outputs are registered.
- States and transitions:
  - IDLE: cmd_ready=1. Command is accepted on cmd_valid&&cmd_ready at edge N; latch len, count, seed, bad; clear frames_sent.
    - If len==0 or count==0: go to DONE, no beats emitted.
    - Otherwise go to SEND; the first beat is valid in cycle N+1.
  - SEND: emit beats. The beat register advances on tvalid&&tready, or on !tvalid.
    - tvalid never drops and tdata/tkeep/tlast/tuser never change while tvalid&&!tready.
    - With tready held high, beats and frames are back-to-back with no bubbles.
  - DONE: done=1 for exactly one cycle, then return to IDLE.
- Beat count per frame = ceil(len/KEEP_WIDTH) (LEN_WIDTH arithmetic; no overflow at max len).
- tkeep: all ones except on the last beat, where it is the low (len mod KEEP_WIDTH) bits set, or all ones if the remainder is 0.
- tlast=1 only on the final beat of each frame.
- tuser[0] = latched bad flag on the last beat; 0 elsewhere.
- Data pattern: byte lane j of beat b in frame i = (seed + i + b*KEEP_WIDTH + j) mod 256.
  - Lanes with tkeep=0 are driven 0.
  - Frame index i wraps mod 256 in the pattern.
- frames_sent increments on each tlast handshake.
- Leaving SEND:
  - After the handshake of the last beat of frame count-1, go to DONE. tvalid deasserts the cycle after that handshake unless a new beat is loaded; none is loaded.
- abort:
  - Sampled each cycle in SEND and latched sticky until DONE.
  - The current frame always completes with its tlast; no further frames start; go to DONE. frames_sent reflects completed frames.
  - abort in IDLE has no effect.
  - abort asserted in the same cycle as the final tlast handshake: normal completion, identical result.
- New command during SEND/DONE: not accepted (cmd_ready=0).
- Simultaneous done and cmd_valid: the command is accepted on the next cycle in IDLE.

Test Plan:
- KEEP_WIDTH=8, len=20, count=2, seed=0x10, tready=1 -> 6 beats back-to-back.
  - Frame 0: beat0 bytes 0x10..0x17, beat2 tkeep=0x0F bytes 0x20..0x23, tlast.
  - Frame 1: first byte 0x11.
  - frames_sent=2, single done pulse, cmd_ready high the cycle after done.
- len=16, count=1, cmd_bad=1 -> 2 beats, last tkeep=0xFF, tuser[0]=1 only on the tlast beat.
- len=0 or count=0 -> no tvalid, done pulses 2 cycles after acceptance, frames_sent=0.
- len=24, count=3, tready toggling pseudo-randomly -> output held stable whenever tvalid&&!tready. Scoreboard matches the pattern exactly; 9 handshakes total.
- len=64, count=10, abort pulsed mid frame 2 -> frame 2 completes with tlast, frames_sent=3, done pulses, no frame 3.
- rst asserted mid-frame (asynchronous, between edges) -> tvalid=0 immediately, state IDLE, cmd_ready=1. A new command then runs normally from frame 0.

Source files
------------

// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream frame source for the C2H DMA path.
// Emits cmd_count frames of cmd_len bytes each. Byte lane j of beat b in
// frame i carries (seed + i + b*KEEP_WIDTH + j) mod 256. On the last beat of
// each frame it asserts tlast, sets tuser[0] to the latched bad flag, and
// trims tkeep.
// Ports:
//   clk, rst              clock, async active-high reset
//   cmd_*                 command handshake (accepted only in IDLE)
//   abort                 finish the current frame, then stop
//   m_axis_*              AXI4-Stream master, all outputs registered
//   busy, done            status: busy in SEND/DONE, done = 1-cycle pulse
//   frames_sent           frames completed for the current/last command
module axis_frame_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16   // must be >= 8: the pattern uses frame[7:0]
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [CNT_WIDTH-1:0]  cmd_count,
  input  logic [7:0]            cmd_seed,
  input  logic                  cmd_bad,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] KW    = LEN_WIDTH'(KEEP_WIDTH);
  localparam logic [LEN_WIDTH-1:0] ONE_L = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  len_q, beat_q, lastb_q;
  logic [CNT_WIDTH-1:0]  count_q, frame_q, frames_sent_q;
  logic [7:0]            seed_q;
  logic                  bad_q, abort_q;
  logic                  cmd_ready_q, busy_q, done_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [KEEP_WIDTH-1:0] tkeep_q;
  logic                  tvalid_q, tlast_q;
  logic [USER_WIDTH-1:0] tuser_q;

  // Candidate beat: on accept it is frame 0 beat 0 of the new command,
  // otherwise the beat following the one currently presented.
  logic                  accept, adv, fin, load;
  logic [LEN_WIDTH-1:0]  ld_len, ld_rem, ld_nbeats, ld_lastb, ld_beat;
  logic [CNT_WIDTH-1:0]  ld_frame;
  logic [7:0]            ld_seed, ld_base;
  logic                  ld_bad, ld_last;
  logic [KEEP_WIDTH-1:0] ld_keep;
  logic [DATA_WIDTH-1:0] ld_data;

  always_comb begin
    accept    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    ld_len    = accept ? cmd_len  : len_q;
    ld_seed   = accept ? cmd_seed : seed_q;
    ld_bad    = accept ? cmd_bad  : bad_q;
    ld_rem    = ld_len % KW;
    // Division form avoids the overflow of (len + KW - 1) at max len.
    ld_nbeats = ld_len / KW + ((ld_rem != '0) ? ONE_L : '0);
    ld_lastb  = accept ? (ld_nbeats - ONE_L) : lastb_q;
    if (accept) begin
      ld_frame = '0;
      ld_beat  = '0;
    end else if (beat_q == lastb_q) begin
      ld_frame = frame_q + ONE_C;
      ld_beat  = '0;
    end else begin
      ld_frame = frame_q;
      ld_beat  = beat_q + ONE_L;
    end
    ld_last = (ld_beat == ld_lastb);
    ld_base = ld_seed + ld_frame[7:0] + 8'(ld_beat * KW);
    ld_keep = '0;
    ld_data = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      ld_keep[j] = !ld_last || (ld_rem == '0) || (LEN_WIDTH'(j) < ld_rem);
      if (ld_keep[j]) ld_data[j*8 +: 8] = ld_base + 8'(j);
    end

    // Beat register may move when the current beat is taken or slot is empty.
    adv  = (state_q == SEND) && (!tvalid_q || m_axis_tready);
    // Final handshake of the command: count reached or abort seen (sticky
    // or in this very cycle).
    fin  = adv && tvalid_q && tlast_q &&
           ((frames_sent_q + ONE_C == count_q) || abort_q || abort);
    load = (accept && (cmd_len != '0) && (cmd_count != '0)) || (adv && !fin);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      beat_q        <= '0;
      lastb_q       <= '0;
      count_q       <= '0;
      frame_q       <= '0;
      frames_sent_q <= '0;
      seed_q        <= '0;
      bad_q         <= 1'b0;
      abort_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      tdata_q       <= '0;
      tkeep_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
      tuser_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            len_q         <= cmd_len;
            count_q       <= cmd_count;
            seed_q        <= cmd_seed;
            bad_q         <= cmd_bad;
            lastb_q       <= ld_lastb;
            abort_q       <= 1'b0;
            frames_sent_q <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ((cmd_len == '0) || (cmd_count == '0)) ? DONE : SEND;
          end
        end
        SEND: begin
          abort_q <= abort_q | abort;
          if (adv && tvalid_q && tlast_q) frames_sent_q <= frames_sent_q + ONE_C;
          if (fin) state_q <= DONE;
        end
        DONE: begin
          // First DONE cycle raises done; the next returns to IDLE, so
          // cmd_ready is never high while done is.
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (load) begin
        tvalid_q   <= 1'b1;
        tdata_q    <= ld_data;
        tkeep_q    <= ld_keep;
        tlast_q    <= ld_last;
        tuser_q    <= '0;
        tuser_q[0] <= ld_last & ld_bad;
        frame_q    <= ld_frame;
        beat_q     <= ld_beat;
      end else if (fin) begin
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
        tkeep_q  <= '0;
        tlast_q  <= 1'b0;
        tuser_q  <= '0;
      end
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frames_sent   = frames_sent_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Bench for axis_frame_gen (DATA_WIDTH=64, KEEP_WIDTH=8). Expected beats come
// from a byte-offset model: byte k of frame i is (seed+i+k)%256 when k<len.
module tb_axis_frame_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_bad, abort;
  logic [15:0] cmd_len, cmd_count;
  logic [7:0]  cmd_seed;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tready, tlast;
  logic [0:0]  tuser;
  logic        busy, done;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  axis_frame_gen dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_count(cmd_count), .cmd_seed(cmd_seed), .cmd_bad(cmd_bad),
    .abort(abort),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  // ---- reference model ----
  function automatic logic [63:0] m_data(int len, int seed, int fr, int b);
    logic [63:0] d;
    d = '0;
    for (int j = 0; j < 8; j++)
      if (b*8 + j < len) d[j*8 +: 8] = 8'((seed + fr + b*8 + j) % 256);
    return d;
  endfunction

  function automatic logic [7:0] m_keep(int len, int b);
    logic [7:0] k;
    k = '0;
    for (int j = 0; j < 8; j++) if (b*8 + j < len) k[j] = 1'b1;
    return k;
  endfunction

  function automatic logic m_last(int len, int b);
    return ((b + 1) * 8 >= len);
  endfunction

  // Drive a command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input int len, input int cnt, input int seed, input bit bad);
    int t;
    t = 0;
    @(negedge clk);
    cmd_len = 16'(len); cmd_count = 16'(cnt); cmd_seed = 8'(seed);
    cmd_bad = bad; cmd_valid = 1'b1;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (tvalid !== 0 || cmd_ready !== 1 || busy !== 0 || done !== 0 ||
        frames_sent !== 0 || tdata !== 0 || tkeep !== 0 || tlast !== 0 || tuser !== 0) begin
      errors++;
      $display("FAIL reset_state: tvalid=%0b cmd_ready=%0b busy=%0b done=%0b fs=%0d tdata=%h required 0,1,0,0,0,0",
               tvalid, cmd_ready, busy, done, frames_sent, tdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1 || tvalid !== 0) begin
      errors++; $display("FAIL reset_release: cmd_ready=%0b tvalid=%0b required 1,0", cmd_ready, tvalid);
    end
  endtask

  task automatic test_basic();
    int fr, b, hs, nd, cyc;
    fr = 0; b = 0; hs = 0; nd = 0; cyc = 0;
    tready = 1'b1;
    send_cmd(20, 2, 'h10, 1'b0);
    checks++;
    if (tvalid !== 1 || busy !== 1 || cmd_ready !== 0) begin
      errors++; $display("FAIL basic_first: tvalid=%0b busy=%0b cmd_ready=%0b required 1,1,0", tvalid, busy, cmd_ready);
    end
    while (nd == 0 && cyc < 100) begin
      if (tvalid) begin
        if (fr == 0 && b == 0) begin
          checks++;
          if (tdata !== 64'h1716151413121110) begin
            errors++; $display("FAIL basic_beat0: tdata=%h required 1716151413121110", tdata);
          end
        end
        if (fr == 0 && b == 2) begin
          checks++;
          if (tdata !== 64'h0000000023222120 || tkeep !== 8'h0F || tlast !== 1'b1) begin
            errors++; $display("FAIL basic_beat2: tdata=%h tkeep=%h tlast=%0b required 23222120,0f,1", tdata, tkeep, tlast);
          end
        end
        if (fr == 1 && b == 0) begin
          checks++;
          if (tdata[7:0] !== 8'h11) begin
            errors++; $display("FAIL basic_f1_byte0: got %h required 11", tdata[7:0]);
          end
        end
        checks++;
        if (fr > 1 || tdata !== m_data(20, 'h10, fr, b) || tkeep !== m_keep(20, b) ||
            tlast !== m_last(20, b) || tuser !== 1'b0) begin
          errors++; $display("FAIL basic_beat f%0d b%0d: tdata=%h tkeep=%h tlast=%0b required %h %h %0b",
                             fr, b, tdata, tkeep, tlast, m_data(20, 'h10, fr, b), m_keep(20, b), m_last(20, b));
        end
        hs++;
        if (m_last(20, b)) begin fr++; b = 0; end else b++;
      end else if (hs < 6) begin
        checks++; errors++; $display("FAIL basic_bubble: tvalid=0 after %0d beats, required 1", hs);
      end
      if (done) nd++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (hs != 6 || nd != 1 || frames_sent !== 16'd2) begin
      errors++; $display("FAIL basic_end: beats=%0d done=%0d fs=%0d required 6,1,2", hs, nd, frames_sent);
    end
    checks++;
    if (done !== 0 || cmd_ready !== 1 || busy !== 0) begin
      errors++; $display("FAIL basic_after_done: done=%0b cmd_ready=%0b busy=%0b required 0,1,0", done, cmd_ready, busy);
    end
  endtask

  task automatic test_bad();
    int b, hs, cyc;
    b = 0; hs = 0; cyc = 0;
    tready = 1'b1;
    send_cmd(16, 1, 'hA0, 1'b1);
    while (!done && cyc < 50) begin
      if (tvalid) begin
        checks++;
        if (tdata !== m_data(16, 'hA0, 0, b) || tkeep !== 8'hFF ||
            tlast !== m_last(16, b) || tuser !== 1'(m_last(16, b))) begin
          errors++; $display("FAIL bad_beat b%0d: tdata=%h tkeep=%h tlast=%0b tuser=%0b required %h ff %0b %0b",
                             b, tdata, tkeep, tlast, tuser, m_data(16, 'hA0, 0, b), m_last(16, b), m_last(16, b));
        end
        hs++; b++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (hs != 2 || frames_sent !== 16'd1 || done !== 1) begin
      errors++; $display("FAIL bad_end: beats=%0d fs=%0d done=%0b required 2,1,1", hs, frames_sent, done);
    end
  endtask

  task automatic test_zero();
    for (int v = 0; v < 2; v++) begin
      send_cmd(v == 0 ? 0 : 7, v == 0 ? 5 : 0, 'h33, 1'b0);
      checks++;
      if (tvalid !== 0 || done !== 0 || frames_sent !== 0 || busy !== 1) begin
        errors++; $display("FAIL zero_accept v%0d: tvalid=%0b done=%0b fs=%0d busy=%0b required 0,0,0,1",
                           v, tvalid, done, frames_sent, busy);
      end
      @(negedge clk);
      checks++;
      if (tvalid !== 0 || done !== 1 || cmd_ready !== 0) begin
        errors++; $display("FAIL zero_done v%0d: tvalid=%0b done=%0b cmd_ready=%0b required 0,1,0", v, tvalid, done, cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (done !== 0 || cmd_ready !== 1 || frames_sent !== 0) begin
        errors++; $display("FAIL zero_idle v%0d: done=%0b cmd_ready=%0b fs=%0d required 0,1,0", v, done, cmd_ready, frames_sent);
      end
    end
  endtask

  task automatic test_backpressure();
    int len, cnt, seed, fr, b, hs, cyc, total;
    bit bad, stall, nd;
    logic [63:0] sd; logic [7:0] sk; logic sl; logic [0:0] su;
    for (int c = 0; c < 5; c++) begin
      len  = (c == 0) ? 24 : int'($urandom_range(1, 40));
      cnt  = (c == 0) ? 3  : int'($urandom_range(1, 4));
      seed = int'($urandom_range(0, 255));
      bad  = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      total = cnt * ((len + 7) / 8);
      fr = 0; b = 0; hs = 0; cyc = 0; stall = 0; nd = 0;
      sd = '0; sk = '0; sl = 0; su = '0;
      tready = 1'b0;
      send_cmd(len, cnt, seed, bad);
      while (!nd && cyc < 2000) begin
        if (stall) begin
          checks++;
          if (tvalid !== 1 || tdata !== sd || tkeep !== sk || tlast !== sl || tuser !== su) begin
            errors++; $display("FAIL bp_hold c%0d: tvalid=%0b tdata=%h tkeep=%h required 1 %h %h", c, tvalid, tdata, tkeep, sd, sk);
          end
        end
        tready = 1'($urandom_range(0, 1));
        stall = tvalid && !tready;
        sd = tdata; sk = tkeep; sl = tlast; su = tuser;
        if (tvalid && tready) begin
          checks++;
          if (fr >= cnt || tdata !== m_data(len, seed, fr, b) || tkeep !== m_keep(len, b) ||
              tlast !== m_last(len, b) || tuser !== 1'(bad && m_last(len, b))) begin
            errors++; $display("FAIL bp_beat c%0d f%0d b%0d: tdata=%h tkeep=%h tlast=%0b tuser=%0b required %h %h %0b %0b",
                               c, fr, b, tdata, tkeep, tlast, tuser, m_data(len, seed, fr, b), m_keep(len, b),
                               m_last(len, b), bad && m_last(len, b));
          end
          hs++;
          if (m_last(len, b)) begin fr++; b = 0; end else b++;
        end
        if (done) nd = 1;
        @(negedge clk); cyc++;
      end
      checks++;
      if (hs != total || frames_sent !== 16'(cnt) || !nd) begin
        errors++; $display("FAIL bp_end c%0d: beats=%0d fs=%0d done=%0b required %0d,%0d,1", c, hs, frames_sent, nd, total, cnt);
      end
    end
    tready = 1'b1;
  endtask

  task automatic test_abort();
    int fr, b, hs, cyc;
    bit nd;
    fr = 0; b = 0; hs = 0; cyc = 0; nd = 0;
    tready = 1'b1;
    send_cmd(64, 10, 'h5C, 1'b0);
    while (!nd && cyc < 300) begin
      abort = (fr == 2 && b == 3 && tvalid);
      if (tvalid) begin
        checks++;
        if (fr > 2 || tdata !== m_data(64, 'h5C, fr, b) || tlast !== m_last(64, b)) begin
          errors++; $display("FAIL abort_beat f%0d b%0d: tdata=%h tlast=%0b required %h %0b (frames 0..2 only)",
                             fr, b, tdata, tlast, m_data(64, 'h5C, fr, b), m_last(64, b));
        end
        hs++;
        if (m_last(64, b)) begin fr++; b = 0; end else b++;
      end
      if (done) nd = 1;
      @(negedge clk); cyc++;
    end
    abort = 1'b0;
    checks++;
    if (hs != 24 || frames_sent !== 16'd3 || !nd) begin
      errors++; $display("FAIL abort_end: beats=%0d fs=%0d done=%0b required 24,3,1", hs, frames_sent, nd);
    end
    @(negedge clk);
    checks++;
    if (tvalid !== 0 || cmd_ready !== 1) begin
      errors++; $display("FAIL abort_idle: tvalid=%0b cmd_ready=%0b required 0,1", tvalid, cmd_ready);
    end
  endtask

  task automatic test_reset_midframe();
    int fr, b, hs, cyc, seed;
    tready = 1'b1;
    send_cmd(64, 4, 'h01, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 0 || cmd_ready !== 1 || busy !== 0 || frames_sent !== 0 || tdata !== 0) begin
      errors++; $display("FAIL rst_mid: tvalid=%0b cmd_ready=%0b busy=%0b fs=%0d tdata=%h required 0,1,0,0,0",
                         tvalid, cmd_ready, busy, frames_sent, tdata);
    end
    @(negedge clk);
    rst = 1'b0;
    seed = int'($urandom_range(0, 255));
    fr = 0; b = 0; hs = 0; cyc = 0;
    send_cmd(10, 2, seed, 1'b0);
    while (!done && cyc < 50) begin
      if (tvalid) begin
        checks++;
        if (fr > 1 || tdata !== m_data(10, seed, fr, b) || tkeep !== m_keep(10, b) || tlast !== m_last(10, b)) begin
          errors++; $display("FAIL rst_rerun f%0d b%0d: tdata=%h tkeep=%h required %h %h",
                             fr, b, tdata, tkeep, m_data(10, seed, fr, b), m_keep(10, b));
        end
        hs++;
        if (m_last(10, b)) begin fr++; b = 0; end else b++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (hs != 4 || frames_sent !== 16'd2 || done !== 1) begin
      errors++; $display("FAIL rst_rerun_end: beats=%0d fs=%0d done=%0b required 4,2,1", hs, frames_sent, done);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_len = 0; cmd_count = 0; cmd_seed = 0;
    cmd_bad = 0; abort = 0; tready = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_bad();
    test_zero();
    test_backpressure();
    test_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
